// File: rtl/svm_pkg.sv
// Shared types and helpers for the support-vector FIFO sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package svm_pkg;

  // Default width of FIFO data and config words.
  localparam int DATA_W_DEF = 9;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  // Index width for a counter covering 0..n-1, never less than one bit.
  function automatic int idx_w(input int n);
    idx_w = (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/svfifo_ctrl_sv_index_counter.sv
// Nested stage/support-vector counter with wrap flags.
// Latency: count updates on the clock edge after inc; flags are combinational from the count.
// Backpressure: none; inc simply holds off counting, clr wins over inc.
//
// Ports:
//   clk, reset_n      clock, async active-low reset
//   clr               synchronous clear of both indices
//   inc               advance by one sample
//   stage_idx, sv_idx current indices
//   first             stage_idx == 0
//   last              stage_idx == STAGE-1
//   last_of_all       last sample of the last support vector
module sv_index_counter
  import svm_pkg::*;
#(
  parameter  int STAGE = 32,
  parameter  int N_SV  = 4,
  localparam int SW    = idx_w(STAGE),
  localparam int VW    = idx_w(N_SV)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          inc,
  output logic [SW-1:0] stage_idx,
  output logic [VW-1:0] sv_idx,
  output logic          first,
  output logic          last,
  output logic          last_of_all
);

  localparam logic [SW-1:0] STAGE_LAST = SW'(STAGE - 1);
  localparam logic [VW-1:0] SV_LAST    = VW'(N_SV - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_idx <= '0;
      sv_idx    <= '0;
    end else if (clr) begin
      stage_idx <= '0;
      sv_idx    <= '0;
    end else if (inc) begin
      if (last) begin
        stage_idx <= '0;
        // Explicit wrap so non-power-of-two N_SV works.
        sv_idx    <= (sv_idx == SV_LAST) ? '0 : sv_idx + VW'(1);
      end else begin
        stage_idx <= stage_idx + SW'(1);
      end
    end
  end

  assign first       = (stage_idx == '0);
  assign last        = (stage_idx == STAGE_LAST);
  assign last_of_all = last && (sv_idx == SV_LAST);

endmodule

// File: rtl/svfifo_ctrl.sv
// Sequencer for the support-vector FIFO: loads N_SV x STAGE config words, then rotates one step per pixel.
// Latency: one cycle from an accepted cfg word or pix_valid to the matching fifo_dv / strobes.
// Backpressure: cfg_ready is high only in LOAD; pix_valid low stalls rotation with all counters held.
//
// Ports:
//   clk, reset_n           clock, async active-low reset
//   start, abort           load request / synchronous return to IDLE (abort wins)
//   cfg_valid/cfg_data     config word stream, cfg_ready accepts
//   pix_valid              one rotation step per cycle it is high (ARMED/RUN only)
//   fifo_dv/fifo_sel/fifo_in  svfifo shift strobe, source select, load data
//   stage_idx/sv_idx       indices of the sample presented with the last step
//   acc_clr/sv_done/vec_done  MAC window strobes, only alongside fifo_dv
//   loaded, busy           status levels
module svfifo_ctrl
  import svm_pkg::*;
#(
  parameter  int STAGE  = 32,
  parameter  int N_SV   = 4,
  parameter  int DATA_W = DATA_W_DEF,
  localparam int SW     = idx_w(STAGE),
  localparam int VW     = idx_w(N_SV)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_valid,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              cfg_ready,
  input  logic              pix_valid,
  output logic              fifo_dv,
  output logic              fifo_sel,
  output logic [DATA_W-1:0] fifo_in,
  output logic [SW-1:0]     stage_idx,
  output logic [VW-1:0]     sv_idx,
  output logic              acc_clr,
  output logic              sv_done,
  output logic              vec_done,
  output logic              loaded,
  output logic              busy
);

  state_e state_q, state_d;

  logic          cfg_hs;    // config word accepted this cycle
  logic          run_step;  // rotation step taken this cycle
  logic          ctr_clr;   // clear both counters (new load or abort)

  logic [SW-1:0] ld_stage;
  logic [VW-1:0] ld_sv;
  logic          ld_first, ld_last, ld_last_all;
  logic [SW-1:0] run_stage;
  logic [VW-1:0] run_sv;
  logic          run_first, run_last, run_last_all;

  // Only the terminal flag of the load count matters; the rest is ignored.
  logic          unused_ld;
  assign unused_ld = ^{ld_stage, ld_sv, ld_first, ld_last};

  sv_index_counter #(.STAGE(STAGE), .N_SV(N_SV)) u_load_ctr (
    .clk         (clk),
    .reset_n     (reset_n),
    .clr         (ctr_clr),
    .inc         (cfg_hs),
    .stage_idx   (ld_stage),
    .sv_idx      (ld_sv),
    .first       (ld_first),
    .last        (ld_last),
    .last_of_all (ld_last_all)
  );

  sv_index_counter #(.STAGE(STAGE), .N_SV(N_SV)) u_run_ctr (
    .clk         (clk),
    .reset_n     (reset_n),
    .clr         (ctr_clr),
    .inc         (run_step),
    .stage_idx   (run_stage),
    .sv_idx      (run_sv),
    .first       (run_first),
    .last        (run_last),
    .last_of_all (run_last_all)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cfg_hs   = 1'b0;
    run_step = 1'b0;
    ctr_clr  = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      ctr_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_LOAD;
            ctr_clr = 1'b1;
          end
        end
        ST_LOAD: begin
          if (cfg_valid && cfg_ready) begin
            cfg_hs = 1'b1;
            if (ld_last_all) state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          // A reload request takes precedence over a waiting pixel.
          if (start) begin
            state_d = ST_LOAD;
            ctr_clr = 1'b1;
          end else if (pix_valid) begin
            run_step = 1'b1;
            state_d  = run_last_all ? ST_ARMED : ST_RUN;
          end
        end
        ST_RUN: begin
          if (pix_valid) begin
            run_step = 1'b1;
            if (run_last_all) state_d = ST_ARMED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Registered outputs; strobes reflect the pre-increment counter values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_ready <= 1'b0;
      fifo_dv   <= 1'b0;
      fifo_sel  <= 1'b0;
      fifo_in   <= '0;
      stage_idx <= '0;
      sv_idx    <= '0;
      acc_clr   <= 1'b0;
      sv_done   <= 1'b0;
      vec_done  <= 1'b0;
      loaded    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cfg_ready <= (state_d == ST_LOAD);
      busy      <= (state_d == ST_LOAD) || (state_d == ST_RUN);
      fifo_dv   <= cfg_hs || run_step;
      acc_clr   <= run_step && run_first;
      sv_done   <= run_step && run_last;
      vec_done  <= run_step && run_last_all;

      if (cfg_hs) begin
        fifo_sel <= 1'b0;
        fifo_in  <= cfg_data;
      end else if (run_step) begin
        fifo_sel <= 1'b1;
      end

      if (run_step) begin
        stage_idx <= run_stage;
        sv_idx    <= run_sv;
      end else if (ctr_clr) begin
        stage_idx <= '0;
        sv_idx    <= '0;
      end

      // loaded rises together with the fifo_dv of the final config word.
      if (ctr_clr)                    loaded <= 1'b0;
      else if (cfg_hs && ld_last_all) loaded <= 1'b1;
    end
  end

endmodule
